div_seq_unit: RTL

DIV_SEQ_UNIT -- requirements
Module: div_seq_unit

---
 rtl/div_seq_unit_if.sv | 26 ++
 rtl/div_seq_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/div_seq_unit_if.sv
// Handshake and result bundle for the sequential divider.
// The master drives the request and operands; the slave returns results and status.
interface div_seq_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             dbz;
  logic             ovf;

  modport master (
    output start, sgn, dividend, divisor,
    input  quotient, remainder, busy, done, dbz, ovf
  );

  modport slave (
    input  start, sgn, dividend, divisor,
    output quotient, remainder, busy, done, dbz, ovf
  );
endinterface

// File: rtl/div_seq_unit.sv
// Sequential restoring divider, one quotient bit per clock.
// Signed mode divides magnitudes and then fixes the result signs, so the
// quotient truncates toward zero and the remainder takes the dividend's sign.
module div_seq_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  div_seq_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic             r_sgn;
  logic [WIDTH-1:0] r_dvd;       // raw dividend as sampled with start
  logic [WIDTH-1:0] r_dvs;       // raw divisor as sampled with start
  logic [WIDTH-1:0] r_dvs_mag;   // divisor magnitude used by the iterations
  logic [WIDTH-1:0] r_prem;      // partial remainder, always below r_dvs_mag
  logic [WIDTH-1:0] r_wq;        // dividend bits shifting out, quotient bits shifting in
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic             r_ovf;

  logic [WIDTH:0]   w_prem;      // shifted partial remainder, one bit wider
  logic             w_ge;        // trial subtraction is non-negative
  logic [WIDTH-1:0] w_sub;
  logic             w_q_neg;
  logic             w_r_neg;
  logic             w_ovf;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;

  // Restoring step: the difference is below the divisor whenever it is kept,
  // so a WIDTH-bit subtraction is exact in that case.
  assign w_prem = {r_prem, r_wq[WIDTH-1]};
  assign w_ge   = (w_prem >= {1'b0, r_dvs_mag});
  assign w_sub  = w_prem[WIDTH-1:0] - r_dvs_mag;

  // Operand magnitudes; unsigned operands pass straight through.
  assign w_dvd_mag = (r_sgn && r_dvd[WIDTH-1]) ? -r_dvd : r_dvd;
  assign w_dvs_mag = (r_sgn && r_dvs[WIDTH-1]) ? -r_dvs : r_dvs;

  // Sign fix-up and overflow detection for the signed result.
  assign w_q_neg = r_sgn && (r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1]);
  assign w_r_neg = r_sgn && r_dvd[WIDTH-1];
  assign w_ovf   = r_sgn && (r_dvd == MOST_NEG) && (r_dvs == {WIDTH{1'b1}});

  assign bus.quotient  = r_quo;
  assign bus.remainder = r_rem;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dbz       = r_dbz;
  assign bus.ovf       = r_ovf;

  // Control FSM with datapath and registered outputs; reset aborts any operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sgn     <= 1'b0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_dvs_mag <= '0;
      r_prem    <= '0;
      r_wq      <= '0;
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_sgn   <= bus.sgn;
            r_dvd   <= bus.dividend;
            r_dvs   <= bus.divisor;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (r_dvs == '0) begin
            // Divide by zero short-circuits straight to a flagged result.
            r_quo   <= '1;
            r_rem   <= r_dvd;
            r_dbz   <= 1'b1;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wq      <= w_dvd_mag;
            r_dvs_mag <= w_dvs_mag;
            r_prem    <= '0;
            r_cnt     <= CNT_W'(WIDTH - 1);
            r_state   <= S_ITER;
          end
        end

        S_ITER: begin
          if (w_ge) begin
            r_prem <= w_sub;
          end else begin
            r_prem <= w_prem[WIDTH-1:0];
          end
          r_wq <= {r_wq[WIDTH-2:0], w_ge};
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_FIX: begin
          r_quo   <= w_q_neg ? -r_wq : r_wq;
          r_rem   <= w_r_neg ? -r_prem : r_prem;
          r_dbz   <= 1'b0;
          r_ovf   <= w_ovf;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
